// File: rtl/axi_sw_ctrlr_pkg.sv
// rtl/axi_sw_ctrlr_pkg.sv - register offsets, response code and FSM state types
package axi_sw_ctrlr_pkg;
   localparam logic [4:0] REG_CTRL     = 5'h00;
   localparam logic [4:0] REG_MASK     = 5'h04;
   localparam logic [4:0] REG_RISE_EN  = 5'h08;
   localparam logic [4:0] REG_FALL_EN  = 5'h0C;
   localparam logic [4:0] REG_EVENT    = 5'h10;
   localparam logic [4:0] REG_STATE    = 5'h14;
   localparam logic [4:0] REG_DEBOUNCE = 5'h18;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_DATA} rd_state_t;
endpackage

// File: rtl/axi_sw_ctrlr_nch_if.sv
// rtl/axi_sw_ctrlr_nch_if.sv - AXI4-Lite bundle between PS master and switch controller
interface axi_sw_ctrlr_nch_if;
   logic [4:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [4:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/sw_debounce_ch.sv
// rtl/sw_debounce_ch.sv - two-flop synchroniser plus counter debouncer for one switch
module sw_debounce_ch #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw,
   input  logic [CNT_W-1:0] period,
   output logic             state
);
   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   // A counter left above a newly written period runs on and wraps before matching.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         cnt   <= '0;
         state <= 1'b0;
      end else begin
         sync <= {sync[0], sw};
         if (sync[1] == state) begin
            cnt <= '0;
         end else if (cnt == period) begin
            state <= ~state;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/axi_sw_ctrlr_nch.sv
// rtl/axi_sw_ctrlr_nch.sv - AXI4-Lite switch controller: debounce, edge select, W1C events, IRQ
module axi_sw_ctrlr_nch
   import axi_sw_ctrlr_pkg::*;
#(
   parameter int          N_CH        = 4,
   parameter int          CNT_W       = 20,
   parameter int unsigned DEB_DEFAULT = 100000
) (
   input  logic                aclk,
   input  logic                areset,
   axi_sw_ctrlr_nch_if.slave   axi,
   output logic                IRQ,
   input  logic [N_CH-1:0]     SW
);
   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   logic wr_fire;

   logic             irq_en;
   logic [N_CH-1:0]  mask, rise_en, fall_en, pending;
   logic [N_CH-1:0]  deb_state, state_q, set_bits, clr_bits;
   logic [CNT_W-1:0] debounce;
   logic [4:0]       waddr, raddr;
   logic [31:0]      rd_word;
   logic             unused_bits;

   assign waddr       = {axi.awaddr[4:2], 2'b00};
   assign raddr       = {axi.araddr[4:2], 2'b00};
   assign axi.bresp   = RESP_OKAY;
   assign axi.rresp   = RESP_OKAY;
   assign unused_bits = ^{axi.awprot, axi.arprot, axi.wstrb, axi.awaddr[1:0],
                          axi.araddr[1:0], axi.wdata};

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sw_debounce_ch #(.CNT_W(CNT_W)) u_deb (
         .clk    (aclk),
         .rst    (areset),
         .sw     (SW[i]),
         .period (debounce),
         .state  (deb_state[i])
      );
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
      end
   end

   always_comb begin
      wr_next     = wr_state;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      wr_fire     = 1'b0;
      case (wr_state)
         WR_IDLE: if (axi.awvalid && axi.wvalid) wr_next = WR_ACK;
         WR_ACK: begin
            axi.awready = 1'b1;
            axi.wready  = 1'b1;
            wr_fire     = 1'b1;
            wr_next     = WR_RESP;
         end
         WR_RESP: begin
            axi.bvalid = 1'b1;
            if (axi.bready) wr_next = WR_IDLE;
         end
         default: wr_next = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_next     = rd_state;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      case (rd_state)
         RD_IDLE: if (axi.arvalid) rd_next = RD_ACK;
         RD_ACK: begin
            axi.arready = 1'b1;
            rd_next     = RD_DATA;
         end
         RD_DATA: begin
            axi.rvalid = 1'b1;
            if (axi.rready) rd_next = RD_IDLE;
         end
         default: rd_next = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      case (raddr)
         REG_CTRL:     rd_word[0]         = irq_en;
         REG_MASK:     rd_word[N_CH-1:0]  = mask;
         REG_RISE_EN:  rd_word[N_CH-1:0]  = rise_en;
         REG_FALL_EN:  rd_word[N_CH-1:0]  = fall_en;
         REG_EVENT:    rd_word[N_CH-1:0]  = pending;
         REG_STATE:    rd_word[N_CH-1:0]  = deb_state;
         REG_DEBOUNCE: rd_word[CNT_W-1:0] = debounce;
         default:      rd_word            = '0;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) axi.rdata <= '0;
      else if (rd_state == RD_ACK) axi.rdata <= rd_word;
   end

   assign set_bits = (deb_state & ~state_q & rise_en) | (~deb_state & state_q & fall_en);
   assign clr_bits = (wr_fire && waddr == REG_EVENT) ? axi.wdata[N_CH-1:0] : '0;

   // Set is OR'd in after the clear so a same-cycle edge is never lost.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         irq_en   <= 1'b0;
         mask     <= '0;
         rise_en  <= '1;
         fall_en  <= '0;
         debounce <= CNT_W'(DEB_DEFAULT);
         pending  <= '0;
         state_q  <= '0;
         IRQ      <= 1'b0;
      end else begin
         if (wr_fire) begin
            case (waddr)
               REG_CTRL:     irq_en   <= axi.wdata[0];
               REG_MASK:     mask     <= axi.wdata[N_CH-1:0];
               REG_RISE_EN:  rise_en  <= axi.wdata[N_CH-1:0];
               REG_FALL_EN:  fall_en  <= axi.wdata[N_CH-1:0];
               REG_DEBOUNCE: debounce <= axi.wdata[CNT_W-1:0];
               default: ;
            endcase
         end
         pending <= (pending & ~clr_bits) | set_bits;
         state_q <= deb_state;
         IRQ     <= irq_en & (|(pending & mask));
      end
   end
endmodule

// File: doc/axi_sw_ctrlr_nch.md
# axi_sw_ctrlr_nch

Parametrised AXI4-Lite switch/button controller for N_CH asynchronous inputs. Each input is synchronised, debounced with a software-programmable period and edge-detected with per-channel rising/falling selection. Detected edges latch into write-1-to-clear pending bits that drive a single level IRQ. It sits on the PS general-purpose AXI-Lite port and supersedes the fixed 4-channel switch controller.

## Interface
- N_CH, 4, number of input channels, 1..32
- CNT_W, 20, debounce counter width
- DEB_DEFAULT, 100000, reset value of DEBOUNCE; must fit in CNT_W bits
- aclk  in  1  system clock; all logic synchronous to it
- areset  in  1  asynchronous, active-high reset
- awaddr/araddr  in  5  byte address; bits [1:0] ignored
- awprot/arprot  in  3  ignored
- awvalid, awready, wdata[31:0], wstrb[3:0] (ignored), wvalid, wready, bresp[1:0], bvalid, bready: AXI4-Lite write channels
- arvalid, arready, rdata[31:0], rresp[1:0], rvalid, rready: AXI4-Lite read channels
- IRQ  out  1  level interrupt, registered
- SW  in  N_CH  raw asynchronous switch inputs

## Operation
- Register map. Bits above N_CH read 0 and ignore writes.
  - 0x00 CTRL: bit0 irq_en, RW
  - 0x04 MASK: 1 = channel contributes to IRQ, RW
  - 0x08 RISE_EN: RW, reset all ones
  - 0x0C FALL_EN: RW, reset 0
  - 0x10 EVENT: pending bits; read returns pending, write-1-to-clear
  - 0x14 STATE: debounced levels, RO
  - 0x18 DEBOUNCE: [CNT_W-1:0] period, RW
  - 0x1C..: read 0, writes ignored, response OKAY
- Write handshake: awready and wready assert together for one cycle when awvalid & wvalid & !bvalid. The register updates on that edge. bvalid rises next cycle and holds until bready. bresp is always 00.
- Read handshake: arready pulses for one cycle when arvalid & !rvalid. rdata and rvalid are registered on the next edge and held until rready. rresp is always 00.
- Synchronisation: each SW bit passes through two flops.
- Debounce, per channel:
  - Counter resets to 0 whenever the synchronised input equals the debounced state.
  - Otherwise the counter increments. When the counter equals DEBOUNCE, the state flips and the counter clears.
  - DEBOUNCE=0 means the state follows the synchronised input with one cycle of lag.
  - A DEBOUNCE write mid-count takes effect on the next compare. Any counter already above the new value counts on and wraps at 2^CNT_W.
- Edge detection: a rise is state 0→1 and requires RISE_EN[i]; a fall is 1→0 and requires FALL_EN[i]. A qualified edge sets pending[i].
- Same-cycle set and W1C on one bit: set wins.
- IRQ = registered (irq_en & |(pending & MASK)).
- MASK changes never clear pending.

## Timing
- Reset values: all AXI outputs 0, IRQ 0, debounced state 0, counters 0, pending 0, CTRL 0, MASK 0, RISE_EN all ones, FALL_EN 0, DEBOUNCE = DEB_DEFAULT.
- A switch held high through reset produces a rise event after the debounce period.
- SW change → sync output: 2 edges. Sync output differs → state flips: DEBOUNCE+1 edges.
- State flip → pending: 1 edge. Pending → IRQ: 1 edge.
- W1C clear → IRQ deasserts 2 edges after the write handshake edge, if no other masked pending bit remains.
- Reset mid-transaction drops all in-flight responses. The master must reissue.

## Structure
- Package axi_sw_ctrlr_pkg holds the register offset localparams (REG_CTRL … REG_DEBOUNCE) and the AXI resp constant RESP_OKAY.
- One sub-module, sw_debounce_ch: synchroniser, counter and state for a single channel, parametrised by CNT_W. It is instantiated N_CH times via generate.
- Edge qualification, pending and IRQ logic, the register file and AXI-Lite FSMs stay in the top level.

## Test plan
- Reset: read all registers → CTRL=0, MASK=0, RISE_EN=0xF, FALL_EN=0, EVENT=0, STATE=0, DEBOUNCE=100000 (N_CH=4).
- DEBOUNCE=4, MASK=1, CTRL=1; raise SW[0] at edge 0 → STATE[0]=1 at edge 7, EVENT[0]=1 at edge 8, IRQ=1 at edge 9.
- Bounce: DEBOUNCE=4; SW[1] toggles high for 3 cycles, low for 1, high for 10 → exactly one rise event. STATE[1] flips 5 edges after the final stable sync value.
- FALL_EN=0x4, RISE_EN=0; press then release SW[2] → EVENT=0x4 only after release. Write EVENT=0x4 → EVENT=0 and IRQ low 2 edges later.
- Same-cycle collision: W1C to EVENT bit 3 on the edge a qualified edge sets it → bit 3 reads 1. With MASK[3]=0, IRQ stays 0 even with irq_en=1.
- AXI: bready held low for 5 cycles → bvalid stays high and no further awready. Read of 0x1C → rdata=0, rresp=00. areset asserted mid-read → rvalid=0 immediately.
